// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared encodings, field positions and widths for the ALU instruction sequencer
package alu_seq_pkg;
  localparam int DW  = 8;
  localparam int FW  = 4;
  localparam int FSW = 2;
  localparam int IW  = 16;
  localparam int RN  = 4;
  localparam int CLS_LSB = 14;
  localparam int FS_LSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 6;
  localparam int IMM_LSB = 0;
  typedef enum logic [1:0] {CL_RR, CL_LDI, CL_RI, CL_NOP} cls_e;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x8 register file, one write port, ra/rb read ports (plus dbg with ALU_SEQ_DBG_EN)
module alu_seq_regfile import alu_seq_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [1:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [1:0]    ra,
  input  logic [1:0]    rb,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [1:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
`endif
);
  logic [DW-1:0] r [RN];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < RN; i++) r[i] <= '0;
    else if (we)
      r[wa] <= wd;
  assign rd_a = r[ra];
  assign rd_b = r[rb];
`ifdef ALU_SEQ_DBG_EN
  assign dbg_data = r[dbg_sel];
`endif
endmodule

// File: rtl/alu_seq.sv
// alu_seq: 3-cycle instruction sequencer driving an external 8-bit ALU; ALU_SEQ_DBG_EN adds dbg_sel/dbg_data
module alu_seq import alu_seq_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [IW-1:0]  instr,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [FSW-1:0] alu_fs,
  input  logic [DW-1:0]  alu_y,
  input  logic [FW-1:0]  alu_flag,
  output logic           wb_valid,
  output logic [1:0]     wb_rd,
  output logic [DW-1:0]  wb_data,
  output logic [FW-1:0]  flag_q
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [1:0]     dbg_sel,
  output logic [DW-1:0]  dbg_data
`endif
);
  state_e        state, state_nx;
  cls_e          cls, cls_q;
  logic          accept;
  logic [1:0]    rd_q;
  logic [DW-1:0] imm, imm_q, result, rf_a, rf_b;
  assign cls    = cls_e'(instr[CLS_LSB +: 2]);
  assign imm    = instr[IMM_LSB +: DW];
  assign accept = instr_valid && instr_ready;
  assign wb_data = result;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state == EXEC ? WB :
               state == WB   ? IDLE :
               (accept && cls != CL_NOP) ? EXEC : IDLE;
  end
  always_comb begin
    instr_ready = state == IDLE;
    wb_valid    = state == WB;
  end
  // LDI keeps the ALU ports untouched; its immediate travels via imm_q instead
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_fs <= '0;
      cls_q  <= CL_RR;
      rd_q   <= '0;
      imm_q  <= '0;
      result <= '0;
      flag_q <= '0;
      wb_rd  <= '0;
    end else begin
      if (accept && cls != CL_NOP) begin
        cls_q <= cls;
        rd_q  <= instr[RD_LSB +: 2];
        imm_q <= imm;
        if (cls != CL_LDI) begin
          alu_a  <= rf_a;
          alu_b  <= cls == CL_RI ? imm : rf_b;
          alu_fs <= instr[FS_LSB +: FSW];
        end
      end
      if (state == EXEC) begin
        result <= cls_q == CL_LDI ? imm_q : alu_y;
        wb_rd  <= rd_q;
        if (cls_q != CL_LDI) flag_q <= alu_flag;
      end
    end
  alu_seq_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_valid),
    .wa       (wb_rd),
    .wd       (result),
    .ra       (instr[RA_LSB +: 2]),
    .rb       (instr[RB_LSB +: 2]),
    .rd_a     (rf_a),
    .rd_b     (rf_b)
`ifdef ALU_SEQ_DBG_EN
    ,
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
`endif
  );
endmodule

// File: doc/alu_seq.md
# alu_seq

Instruction sequencer that acts as the initiator for the 8-bit ALU datapath. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from a 4×8 register file. It drives the ALU operand/function-select ports, captures the combinational ALU result and 4-bit flags, and writes them back. It sits between the instruction source (bench or fetch unit) and the ALU.

## Interface
- No parameters. Widths are fixed: data 8, flags 4, fs 2, instruction 16.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction word present
- instr_ready  out  1  sequencer can accept; high only in IDLE
- instr  in  16  instruction word
- alu_a  out  8  ALU operand A (registered)
- alu_b  out  8  ALU operand B (registered)
- alu_fs  out  2  ALU function select (registered; passed through from instr)
- alu_y  in  8  ALU result (combinational from alu_a/alu_b/alu_fs)
- alu_flag  in  4  ALU flags
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  2  writeback destination
- wb_data  out  8  writeback value
- flag_q  out  4  last captured ALU flags
- dbg_sel  in  2  register read select (only with ALU_SEQ_DBG_EN)
- dbg_data  out  8  R[dbg_sel], combinational (only with ALU_SEQ_DBG_EN)

## Operation
- Instruction fields:
  - [15:14] class: 00 ALU_RR, 01 LDI, 10 ALU_RI, 11 NOP.
  - [13:12] fs, [11:10] rd, [9:8] ra, [7:6] rb (RR only), [7:0] imm (LDI/RI).
- Transfer occurs on an edge where instr_valid and instr_ready are both high. The source holds instr stable until it is accepted.
- FSM:
  - IDLE → EXEC on acceptance of RR, RI or LDI.
  - NOP is accepted and discarded. The FSM stays in IDLE.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- On acceptance:
  - alu_a ← R[ra].
  - alu_b ← R[rb] (RR) or imm (RI).
  - alu_fs ← fs.
  - rd and class are latched.
  - For LDI, alu_a/alu_b/alu_fs hold their previous values.
- End of EXEC: result register ← alu_y (RR/RI) or imm (LDI). flag_q ← alu_flag for RR/RI only. LDI leaves flag_q unchanged.
- WB cycle: wb_valid=1, wb_rd=rd, wb_data=result. R[rd] is written at the end of WB.
- wb_rd and wb_data hold their last values outside WB. They are only meaningful while wb_valid=1.
- Arithmetic is done entirely in the ALU. The sequencer performs no width extension or modification.
- Reset (async, any state):
  - FSM → IDLE.
  - R0–R3, alu_a, alu_b, alu_fs, result, flag_q, wb_rd, wb_data all = 0.
  - wb_valid=0. instr_ready=1 once rst_n is released.
  - An in-flight instruction is discarded with no writeback.

## Timing
- Acceptance at edge k:
  - EXEC is cycle k+1, with ALU ports stable for the whole cycle.
  - WB is cycle k+2, with wb_valid high.
  - R[rd] is updated at the end of k+2.
  - instr_ready is high again in k+3.
- Throughput: one non-NOP instruction per 3 cycles. One NOP per cycle.
- No hazards: the next instruction reads the register file after the write has completed, so no bypass is needed.
- instr_valid high during EXEC/WB is ignored until IDLE.

## Configuration
- ALU_SEQ_DBG_EN defined: the dbg_sel/dbg_data ports exist, and dbg_data = R[dbg_sel] combinationally.
- ALU_SEQ_DBG_EN undefined: the ports are absent. All other behaviour is identical.

## Structure
- alu_seq_pkg holds:
  - the class encodings,
  - the FSM state enum (IDLE, EXEC, WB),
  - instruction field position constants,
  - width constants.
- Sub-module alu_seq_regfile: 4×8 registers with async reset, one write port and read ports for ra, rb and dbg.

## Test plan
- Reset: hold rst_n=0 → instr_ready=1, wb_valid=0, alu_a/alu_b/alu_fs/flag_q=0, all registers 0.
- LDI R1,0x02 (0x4402) → wb_valid in cycle k+2, wb_rd=1, wb_data=0x02, flag_q unchanged, R1=0x02.
- RR path:
  - Stimulus: LDI R0,0x01 (0x4001), then RR fs=10 rd=R2 ra=R1 rb=R0 (0x2900).
  - EXEC: alu_a=0x02, alu_b=0x01, alu_fs=10. Bench drives alu_y=0x03 and alu_flag=0000.
  - Response: wb_data=0x03, R2=0x03, flag_q=0000.
- RI fs=01 rd=R3 ra=R1 imm=0x12 (0x9D12) → alu_a=0x02, alu_b=0x12, alu_fs=01. Bench alu_y=0x12, flag=0100 → R3=0x12, flag_q=0100.
- Backpressure/NOP:
  - Hold instr_valid high through EXEC/WB → instr_ready=0 and no acceptance until IDLE.
  - NOP (0xC000) → accepted in one cycle, no wb_valid, instr_ready stays 1.
- Reset mid-op: pull rst_n low during EXEC → wb_valid never asserts, registers clear, FSM in IDLE after release.
